// File: rtl/gpu_sprite_pkg.sv
// gpu_sprite_pkg: shared widths, line-list entry type and eval FSM states for the sprite compositor.
package gpu_sprite_pkg;
  localparam int LEVELS = 64;
  localparam int ID_W = 6;
  localparam int POS_W = 10;
  localparam int COLOR_W = 16;
  localparam logic [COLOR_W-1:0] COLOR_DISABLED = 16'h0000;
  typedef struct packed {
    logic [POS_W-1:0]   x;
    logic [COLOR_W-1:0] color;
    logic [ID_W-1:0]    id;
  } line_entry_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_READY} eval_state_e;
endpackage

// File: rtl/sprite_line_buffer.sv
// sprite_line_buffer: double-banked per-line sprite list; back bank is written, front bank is read.
module sprite_line_buffer
  import gpu_sprite_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  line_entry_t             wdata_i,
  input  logic                    ovf_set_i,
  input  logic                    swap_i,
  output line_entry_t [DEPTH-1:0] front_o,
  output logic [CW-1:0]           front_cnt_o,
  output logic                    front_ovf_o
);
  line_entry_t [DEPTH-1:0] ent_q [2];
  logic [CW-1:0] cnt_q [2];
  logic [1:0] ovf_q;
  logic bk_q, fr, full;
  assign fr = ~bk_q;
  assign full = cnt_q[bk_q] == CW'(DEPTH);
  assign front_o = ent_q[fr];
  assign front_cnt_o = cnt_q[fr];
  assign front_ovf_o = ovf_q[fr];
  // A write on the swap clock still lands in the outgoing back bank before it becomes front.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bk_q <= 1'b0;
      ent_q <= '{default: '0};
      cnt_q <= '{default: '0};
      ovf_q <= '0;
    end else begin
      if (we_i && !full) begin
        ent_q[bk_q][cnt_q[bk_q][CW-2:0]] <= wdata_i;
        cnt_q[bk_q] <= cnt_q[bk_q] + 1'b1;
      end
      if ((we_i && full) || ovf_set_i) ovf_q[bk_q] <= 1'b1;
      if (swap_i) begin
        bk_q <= fr;
        cnt_q[fr] <= '0;
        ovf_q[fr] <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/gpu_sprite_compositor.sv
// gpu_sprite_compositor: per-line sprite evaluation in h-blank and pixel compositing over background.
// Optional SPRITE_COLLISION_EN adds frame-sticky collision_flag/collision_id outputs.
module gpu_sprite_compositor
  import gpu_sprite_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL = 525,
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int MAX_PER_LINE = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [POS_W-1:0]            h_pos,
  input  logic [POS_W-1:0]            v_pos,
  input  logic [LEVELS*ID_W-1:0]      sprite_id_in,
  input  logic [LEVELS*POS_W-1:0]     sprite_x_in,
  input  logic [LEVELS*POS_W-1:0]     sprite_y_in,
  input  logic [LEVELS*COLOR_W-1:0]   sprite_color_in,
  input  logic [COLOR_W-1:0]          bg_pixel_in,
  output logic [COLOR_W-1:0]          pixel_out,
  output logic                        pixel_valid,
  output logic                        sprite_hit,
  output logic [ID_W-1:0]             sprite_hit_id,
  output logic                        line_overflow
`ifdef SPRITE_COLLISION_EN
  ,
  output logic                        collision_flag,
  output logic [ID_W-1:0]             collision_id
`endif
);
  localparam int CW = $clog2(MAX_PER_LINE) + 1;
  localparam logic [POS_W-1:0] HA = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] HT1 = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] VA = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] VT1 = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W:0] SW = (POS_W+1)'(SPRITE_W);
  localparam logic [POS_W:0] SH = (POS_W+1)'(SPRITE_H);
  logic [LEVELS-1:0][ID_W-1:0] sid_q;
  logic [LEVELS-1:0][POS_W-1:0] sx_q, sy_q;
  logic [LEVELS-1:0][COLOR_W-1:0] scol_q;
  eval_state_e st_q, st_d;
  logic [ID_W-1:0] lvl_q, lvl_d;
  logic [POS_W-1:0] nl_q, nl_d, nl;
  logic snap, swap, lvl_hit, we, active, cov, win_hit;
  line_entry_t went, win;
  line_entry_t [MAX_PER_LINE-1:0] front;
  logic [CW-1:0] front_cnt;
  logic front_ovf;
  logic [COLOR_W-1:0] pix_q;
  logic valid_q, hit_q, lovf_q;
  logic [ID_W-1:0] hid_q;
  assign snap = v_pos == VA && h_pos == '0;
  assign active = h_pos < HA && v_pos < VA;
  assign pixel_out = pix_q;
  assign pixel_valid = valid_q;
  assign sprite_hit = hit_q;
  assign sprite_hit_id = hid_q;
  assign line_overflow = lovf_q;
  // Evaluation reads only these shadow copies, so table updates mid-frame cannot tear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sid_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      scol_q <= '0;
    end else if (snap) begin
      sid_q <= sprite_id_in;
      sx_q <= sprite_x_in;
      sy_q <= sprite_y_in;
      scol_q <= sprite_color_in;
    end
  end
  always_comb begin
    nl = (v_pos == VT1) ? '0 : v_pos + 1'b1;
    lvl_hit = scol_q[lvl_q] != COLOR_DISABLED && {1'b0, sy_q[lvl_q]} <= {1'b0, nl_q}
              && {1'b0, nl_q} < {1'b0, sy_q[lvl_q]} + SH;
    we = st_q == ST_SCAN && lvl_hit;
    went = {sx_q[lvl_q], scol_q[lvl_q], sid_q[lvl_q]};
    swap = st_q != ST_IDLE && h_pos == HT1;
    st_d = st_q;
    lvl_d = lvl_q;
    nl_d = nl_q;
    if (swap) st_d = ST_IDLE;
    else if (st_q == ST_IDLE && h_pos == HA) begin
      st_d = nl >= VA ? ST_READY : ST_SCAN;
      lvl_d = '1;
      nl_d = nl;
    end else if (st_q == ST_SCAN) begin
      st_d = lvl_q == '0 ? ST_READY : ST_SCAN;
      lvl_d = lvl_q - 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= ST_IDLE;
      lvl_q <= '0;
      nl_q <= '0;
    end else begin
      st_q <= st_d;
      lvl_q <= lvl_d;
      nl_q <= nl_d;
    end
  end
  sprite_line_buffer #(.DEPTH(MAX_PER_LINE)) u_lbuf (
    .clk        (clk),
    .rst        (rst),
    .we_i       (we),
    .wdata_i    (went),
    .ovf_set_i  (swap && st_q == ST_SCAN),
    .swap_i     (swap),
    .front_o    (front),
    .front_cnt_o(front_cnt),
    .front_ovf_o(front_ovf)
  );
`ifdef SPRITE_COLLISION_EN
  logic sec_hit, coll_q, coll_out_q;
  logic [ID_W-1:0] sec_id, cid_q, cid_out_q;
  assign collision_flag = coll_out_q;
  assign collision_id = cid_out_q;
`endif
  // Entry 0 is the highest-priority level; the first covering entry wins.
  always_comb begin
    cov = 1'b0;
    win_hit = 1'b0;
    win = '0;
`ifdef SPRITE_COLLISION_EN
    sec_hit = 1'b0;
    sec_id = '0;
`endif
    for (int i = 0; i < MAX_PER_LINE; i++) begin
      cov = CW'(i) < front_cnt && {1'b0, front[i].x} <= {1'b0, h_pos}
            && {1'b0, h_pos} < {1'b0, front[i].x} + SW;
`ifdef SPRITE_COLLISION_EN
      if (cov && win_hit && !sec_hit) begin
        sec_hit = 1'b1;
        sec_id = front[i].id;
      end
`endif
      if (cov && !win_hit) begin
        win_hit = 1'b1;
        win = front[i];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q <= '0;
      valid_q <= 1'b0;
      hit_q <= 1'b0;
      hid_q <= '0;
      lovf_q <= 1'b0;
    end else begin
      pix_q <= active ? (win_hit ? win.color : bg_pixel_in) : '0;
      valid_q <= active;
      hit_q <= active && win_hit;
      hid_q <= (active && win_hit) ? win.id : '0;
      lovf_q <= front_ovf;
    end
  end
`ifdef SPRITE_COLLISION_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_q <= 1'b0;
      cid_q <= '0;
      coll_out_q <= 1'b0;
      cid_out_q <= '0;
    end else if (snap) begin
      coll_out_q <= coll_q;
      cid_out_q <= cid_q;
      coll_q <= 1'b0;
      cid_q <= '0;
    end else if (active && sec_hit && !coll_q) begin
      coll_q <= 1'b1;
      cid_q <= sec_id;
    end
  end
`endif
endmodule
